top_core: RTL and testbench

TOP_CORE -- requirements
Module: top_core

---
 rtl/top_core.sv | 225 ++++++++++++++++++++++
 tb/tb_top_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/top_core.sv
// SPI-loadable 256-word memory with a small multi-cycle core that runs from it.
// Define TOP_CORE_MUL_EN to build op4 as a multiply; otherwise op4 is a NOP.

// state  | meaning
// IDLE   | waiting for both run enables
// FETCH  | read instruction at PC (stalls while SPI uses memory)
// EXEC   | execute ALU/branch/OUT, or decide on a memory op
// MEM    | LW/SW access (stalls while SPI uses memory)
// HALT   | stopped until reset

module top_core (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_enable_i,
   input  logic        en_ifetch_i,
   input  logic        spi_sclk,
   input  logic        spi_cs,
   input  logic        spi_sdi0,
   input  logic        spi_sdi1,
   input  logic        spi_sdi2,
   input  logic        spi_sdi3,
   output logic        spi_sdo0,
   output logic        spi_sdo1,
   output logic        spi_sdo2,
   output logic        spi_sdo3,
   output logic [1:0]  spi_mode,
   output logic [31:0] gpio_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   logic [31:0] mem [256];

   logic [1:0]  sclk_sync, cs_sync, sdi_sync;
   logic        sclk_d;
   logic        sclk_rise, sclk_fall, cs_act;
   logic [6:0]  bit_cnt;
   logic [31:0] shift_q, shift_nxt, tx_q;
   logic [7:0]  addr_q;
   logic        cmd_rd, ignore_q, wr_pend, rd_pend, tx_vld, sdo_q, spi_busy;

   assign spi_sdo0  = sdo_q;
   assign spi_sdo1  = 1'b0;
   assign spi_sdo2  = 1'b0;
   assign spi_sdo3  = 1'b0;
   assign spi_mode  = 2'b00;
   assign sclk_rise = sclk_sync[1] & ~sclk_d;
   assign sclk_fall = ~sclk_sync[1] & sclk_d;
   assign cs_act    = ~cs_sync[1];
   assign shift_nxt = {shift_q[30:0], sdi_sync[1]};
   assign spi_busy  = wr_pend | rd_pend;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sclk_sync <= 2'b00;
         cs_sync   <= 2'b11;
         sdi_sync  <= 2'b00;
         sclk_d    <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[0], spi_sclk};
         cs_sync   <= {cs_sync[0], spi_cs};
         sdi_sync  <= {sdi_sync[0], spi_sdi0};
         sclk_d    <= sclk_sync[1];
      end
   end

   // Frame: 8 cmd bits, 32 addr bits, 32 data bits; counter parks at 72.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_cnt  <= '0;
         shift_q  <= '0;
         tx_q     <= '0;
         addr_q   <= '0;
         cmd_rd   <= 1'b0;
         ignore_q <= 1'b0;
         wr_pend  <= 1'b0;
         rd_pend  <= 1'b0;
         tx_vld   <= 1'b0;
         sdo_q    <= 1'b0;
      end else begin
         wr_pend <= 1'b0;
         rd_pend <= 1'b0;
         if (rd_pend) begin
            tx_q   <= mem[addr_q];
            tx_vld <= 1'b1;
         end
         if (!cs_act) begin
            bit_cnt  <= '0;
            cmd_rd   <= 1'b0;
            ignore_q <= 1'b0;
            tx_vld   <= 1'b0;
            sdo_q    <= 1'b0;
         end else begin
            if (sclk_rise && !ignore_q && bit_cnt != 7'd72) begin
               shift_q <= shift_nxt;
               bit_cnt <= bit_cnt + 7'd1;
               case (bit_cnt)
                  7'd7: begin
                     cmd_rd   <= (shift_nxt[7:0] == 8'h03);
                     ignore_q <= (shift_nxt[7:0] != 8'h02) && (shift_nxt[7:0] != 8'h03);
                  end
                  7'd39: begin
                     addr_q  <= shift_nxt[9:2];
                     rd_pend <= cmd_rd;
                  end
                  7'd71:   wr_pend <= ~cmd_rd;
                  default: ;
               endcase
            end
            if (sclk_fall && tx_vld) begin
               sdo_q <= tx_q[31];
               tx_q  <= {tx_q[30:0], 1'b0};
            end
         end
      end
   end

   state_t      state_q, state_d;
   logic [9:0]  pc_q;
   logic [31:0] ir_q;
   logic [31:0] regs [16];
   logic [3:0]  op, rd, rs1, rs2;
   logic [31:0] imm_sx, rs1_v, rs2_v, ea, wb_val;
   logic [7:0]  mem_idx;
   logic        run, fetch_go, exec_go, mem_go, wb_en;
   logic        unused_bits;

   assign op      = ir_q[31:28];
   assign rd      = ir_q[27:24];
   assign rs1     = ir_q[23:20];
   assign rs2     = ir_q[19:16];
   assign imm_sx  = {{16{ir_q[15]}}, ir_q[15:0]};
   assign rs1_v   = (rs1 == 4'd0) ? 32'd0 : regs[rs1];
   assign rs2_v   = (rs2 == 4'd0) ? 32'd0 : regs[rs2];
   assign ea      = rs1_v + imm_sx;
   assign mem_idx = ea[9:2];
   assign run     = fetch_enable_i & en_ifetch_i;
   assign fetch_go = (state_q == S_FETCH) && run && !spi_busy;
   assign exec_go  = (state_q == S_EXEC) && run;
   assign mem_go   = (state_q == S_MEM) && run && !spi_busy;
   assign unused_bits = ^{spi_sdi1, spi_sdi2, spi_sdi3, ea[31:10], ea[1:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (run) state_d = S_FETCH;
         S_FETCH: if (fetch_go) state_d = S_EXEC;
         S_EXEC: begin
            if (exec_go) begin
               if (op == 4'd0)                     state_d = S_HALT;
               else if (op == 4'd5 || op == 4'd6)  state_d = S_MEM;
               else                                state_d = S_FETCH;
            end
         end
         S_MEM:   if (mem_go) state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wb_en  = 1'b0;
      wb_val = '0;
      case (op)
         4'd1: begin wb_en = exec_go; wb_val = imm_sx;        end
         4'd2: begin wb_en = exec_go; wb_val = rs1_v + rs2_v; end
         4'd3: begin wb_en = exec_go; wb_val = rs1_v - rs2_v; end
         4'd4: begin
`ifdef TOP_CORE_MUL_EN
            wb_en  = exec_go;
            wb_val = rs1_v * rs2_v;
`endif
         end
         4'd5: begin wb_en = mem_go;  wb_val = mem[mem_idx];  end
         4'd9: begin wb_en = exec_go; wb_val = rs1_v + imm_sx; end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else if (wb_en && rd != 4'd0) begin
         regs[rd] <= wb_val;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q   <= 10'h080;
         ir_q   <= '0;
         gpio_o <= '0;
      end else begin
         if (fetch_go) ir_q <= mem[pc_q[9:2]];
         if (exec_go) begin
            if (op == 4'd8) gpio_o <= rs1_v;
            if (op == 4'd7 && rs1_v != rs2_v)
               pc_q <= pc_q + {ir_q[7:0], 2'b00};
            else if (op != 4'd0 && op != 4'd5 && op != 4'd6)
               pc_q <= pc_q + 10'd4;
         end
         if (mem_go) pc_q <= pc_q + 10'd4;
      end
   end

   // SPI writes win; the core only writes when SPI is not using memory.
   always_ff @(posedge clk_i) begin
      if (wr_pend)
         mem[addr_q] <= shift_q;
      else if (mem_go && op == 4'd6)
         mem[mem_idx] <= rs2_v;
   end

endmodule

// File: tb/tb_top_core.sv
// Directed bench for top_core: SPI frames, core programs, freeze, reset and address wrap.
module tb_top_core;

   logic        clk_i = 1'b0;
   logic        rst_i, fetch_enable_i, en_ifetch_i;
   logic        spi_sclk, spi_cs, spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3;
   logic        spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
   logic [1:0]  spi_mode;
   logic [31:0] gpio_o;

   int checks = 0;
   int errors = 0;

   top_core dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .fetch_enable_i(fetch_enable_i), .en_ifetch_i(en_ifetch_i),
      .spi_sclk(spi_sclk), .spi_cs(spi_cs),
      .spi_sdi0(spi_sdi0), .spi_sdi1(spi_sdi1), .spi_sdi2(spi_sdi2), .spi_sdi3(spi_sdi3),
      .spi_sdo0(spi_sdo0), .spi_sdo1(spi_sdo1), .spi_sdo2(spi_sdo2), .spi_sdo3(spi_sdo3),
      .spi_mode(spi_mode), .gpio_o(gpio_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [31:0] PROG1 [3] = '{32'h110000FF, 32'h80100000, 32'h00000FFF};
   localparam logic [31:0] PROG2 [17] = '{
      32'h11000005, 32'h12000000, 32'h22210000, 32'h9110FFFF, 32'h7010FFFE,
      32'h60020100, 32'h53000100, 32'h34030000, 32'h45330000, 32'h26450000,
      32'hA6000001, 32'h80600000, 32'h10000007, 32'h26600000, 32'h80600000,
      32'h00000FFF, 32'h00000FFF};
`ifdef TOP_CORE_MUL_EN
   localparam logic [31:0] PROG2_GPIO = 32'h000000D2;
`else
   localparam logic [31:0] PROG2_GPIO = 32'hFFFFFFF1;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // sdi changes while sclk is low; sdo is sampled as sclk rises.
   task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int nbits, output logic [31:0] rd);
      logic [71:0] f;
      f  = {cmd, addr, data};
      rd = '0;
      @(negedge clk_i);
      spi_cs = 1'b0;
      #40;
      for (int i = 0; i < nbits; i++) begin
         spi_sdi0 = f[71-i];
         #50;
         spi_sclk = 1'b1;
         if (i >= 40) rd = {rd[30:0], spi_sdo0};
         #50;
         spi_sclk = 1'b0;
      end
      #40;
      spi_cs = 1'b1;
      #100;
   endtask

   task automatic spi_wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] dummy;
      spi_frame(8'h02, addr, data, 72, dummy);
   endtask

   task automatic spi_rd(input logic [31:0] addr, output logic [31:0] data);
      spi_frame(8'h03, addr, 32'h0, 72, data);
   endtask

   task automatic pulse_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic wait_halt(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (dut.state_q != 3'd4 && n < max_cyc) begin
         @(negedge clk_i);
         n++;
      end
      check(tag, 32'(dut.state_q), 32'd4);
   endtask

   initial begin
      logic [31:0] rdata;
      int          cyc;

      rst_i = 1'b1; fetch_enable_i = 1'b0; en_ifetch_i = 1'b0;
      spi_sclk = 1'b0; spi_cs = 1'b1; spi_sdi0 = 1'b0;
      spi_sdi1 = 1'b1; spi_sdi2 = 1'b1; spi_sdi3 = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_gpio", gpio_o, 32'h0);
      check("rst_sdo0", 32'(spi_sdo0), 32'h0);
      check("rst_sdo123_mode", {27'h0, spi_sdo1, spi_sdo2, spi_sdo3, spi_mode}, 32'h0);
      check("rst_pc", 32'(dut.pc_q), 32'h80);
      check("rst_state", 32'(dut.state_q), 32'd0);
      rst_i = 1'b0;

      spi_wr(32'h84, 32'hDEADBEEF);
      spi_rd(32'h84, rdata);
      check("spi_rd_deadbeef", rdata, 32'hDEADBEEF);
      check("sdo0_idle_after_read", 32'(spi_sdo0), 32'h0);

      for (int i = 0; i < 3; i++) spi_wr(32'h80 + 32'(4*i), PROG1[i]);
      @(negedge clk_i);
      fetch_enable_i = 1'b1; en_ifetch_i = 1'b1;
      cyc = 0;
      while (gpio_o !== 32'd255 && cyc < 20) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      check("prog1_gpio", gpio_o, 32'd255);
      check("prog1_within_10", 32'(cyc <= 10), 32'd1);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("prog1_halt", 32'(dut.state_q), 32'd4);
      fetch_enable_i = 1'b0; en_ifetch_i = 1'b0;

      pulse_reset();
      check("reset_clears_gpio", gpio_o, 32'h0);
      check("reset_pc", 32'(dut.pc_q), 32'h80);

      for (int i = 0; i < 17; i++) spi_wr(32'h80 + 32'(4*i), PROG2[i]);
      @(negedge clk_i);
      fetch_enable_i = 1'b1; en_ifetch_i = 1'b1;
      repeat (11) @(posedge clk_i);
      @(negedge clk_i);
      check("freeze_pc_start", 32'(dut.pc_q), 32'h88);
      en_ifetch_i = 1'b0;
      repeat (20) @(negedge clk_i);
      check("freeze_pc_end", 32'(dut.pc_q), 32'h88);
      check("freeze_state", 32'(dut.state_q), 32'd1);
      check("freeze_gpio", gpio_o, 32'h0);
      en_ifetch_i = 1'b1;
      wait_halt("prog2_halt", 400);
      check("prog2_gpio", gpio_o, PROG2_GPIO);
      fetch_enable_i = 1'b0; en_ifetch_i = 1'b0;
      spi_rd(32'h100, rdata);
      check("prog2_sw_result", rdata, 32'd15);

      pulse_reset();
      @(negedge clk_i);
      fetch_enable_i = 1'b1; en_ifetch_i = 1'b1;
      repeat (15) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("midrst_gpio", gpio_o, 32'h0);
      check("midrst_pc", 32'(dut.pc_q), 32'h80);
      check("midrst_state", 32'(dut.state_q), 32'd0);
      rst_i = 1'b0;
      wait_halt("rerun_halt", 400);
      check("rerun_gpio", gpio_o, PROG2_GPIO);
      fetch_enable_i = 1'b0; en_ifetch_i = 1'b0;
      spi_rd(32'h80, rdata);
      check("mem_preserved", rdata, 32'h11000005);

      spi_wr(32'h480, 32'h12345678);
      spi_rd(32'h080, rdata);
      check("addr_wrap", rdata, 32'h12345678);
      spi_frame(8'h02, 32'h80, 32'hCAFEF00D, 20, rdata);
      spi_rd(32'h80, rdata);
      check("abort_no_write", rdata, 32'h12345678);
      spi_frame(8'h05, 32'h80, 32'hAAAAAAAA, 72, rdata);
      spi_rd(32'h80, rdata);
      check("bad_cmd_ignored", rdata, 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
